enc_selector: RTL and testbench
===============================

Name: enc_selector

Overview:
- Output stage of the RS encoder datapath, directly downstream of the encoder controller.
- Each cycle it uses the controller's selection phase, request count and buffer offsets to assemble one ENC_SYM-symbol output word from the message buffer and the parity buffer.
- Registers the word and emits codeword framing: start/end markers with lane indices, plus a running codeword count.

Parameters:
- SYM_WID, 8, bits per RS symbol
- ENC_SYM, 4, symbols per output word (lane 0 is transmitted first)
- RSC_MES_LEN, 11, message symbols per codeword
- RSC_PAR_LEN, 4, parity symbols per codeword
- RSC_COD_LEN, 15, codeword length; must equal RSC_MES_LEN + RSC_PAR_LEN
- ENC_MES_BUF_DEP, 8, message buffer depth in symbols
- ENC_PAR_BUF_DEP, 8, parity buffer depth in symbols

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sel_phase  in  SEL_PHASE  SEL_IDL / SEL_PAR / SEL_MES
- sel_request  in  clog2(ENC_SYM+1)  number of message symbols in this word
- sel_mes_offset  in  clog2(ENC_MES_BUF_DEP+1)  first message buffer index
- sel_par_offset  in  clog2(ENC_PAR_BUF_DEP+1)  first parity buffer index
- mes_buf  in  ENC_MES_BUF_DEP*SYM_WID  message buffer; symbol k at bits [k*SYM_WID +: SYM_WID]
- par_buf  in  ENC_PAR_BUF_DEP*SYM_WID  parity buffer, same packing
- out_valid  out  1  word valid
- out_data  out  ENC_SYM*SYM_WID  output word; lane i at bits [i*SYM_WID +: SYM_WID]
- out_sop  out  1  word contains the first symbol of a codeword
- out_sop_lane  out  clog2(ENC_SYM)  lane of that first symbol
- out_eop  out  1  word contains the last symbol of a codeword
- out_eop_lane  out  clog2(ENC_SYM)  lane of that last symbol
- out_cw_cnt  out  16  completed codewords, wraps at 2^16

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: all outputs are 0. Internal position counter pos = 0. Reset asserted mid-word discards the word and takes effect on that edge.
- Latency: registered, 1 cycle from the sel_* inputs to out_*.
- Word composition, with r = sel_request:
  - SEL_IDL: out_valid 0 next cycle. out_data, sop and eop are held; pos is unchanged.
  - SEL_MES: lanes 0..r-1 = mes_buf[sel_mes_offset+i]. Lanes r..ENC_SYM-1 = par_buf[sel_par_offset+(i-r)].
  - SEL_PAR: lanes 0..ENC_SYM-r-1 = par_buf[sel_par_offset+i], the parity tail of the previous codeword. Lanes ENC_SYM-r..ENC_SYM-1 = mes_buf[sel_mes_offset+(i-(ENC_SYM-r))].
- Index arithmetic: buffer indices are computed at offset width + 1 bit. An out-of-range index yields symbol 0.
- pos: position within the codeword (width clog2(RSC_COD_LEN)) of the symbol on lane 0.
- Framing on a valid word (evaluate the sop and eop rules independently):
  - sop, message-led: SEL_MES and pos == 0 -> sop = 1, sop_lane = 0.
  - sop/eop, boundary word: SEL_PAR and 0 < r < ENC_SYM -> eop = 1 with eop_lane = ENC_SYM-r-1, sop = 1 with sop_lane = ENC_SYM-r; next pos = r (resync).
  - eop, parity-led: SEL_PAR, r == 0 and pos+ENC_SYM >= RSC_COD_LEN -> eop = 1, eop_lane = RSC_COD_LEN-1-pos; next pos = pos+ENC_SYM-RSC_COD_LEN.
  - otherwise: next pos = pos+ENC_SYM, wrapping modulo RSC_COD_LEN.
- out_cw_cnt increments by 1 on the edge that registers out_eop = 1. 0xFFFF wraps to 0.
- sel_request > ENC_SYM: clamp to ENC_SYM.

Optional Feature:
- Macro: ENC_SEL_CHK_EN.
- Defined:
  - Adds output `sel_err` (1 bit, reset 0, sticky until rst).
  - Set when a valid word has sel_mes_offset + r > ENC_MES_BUF_DEP, sel_par_offset + (ENC_SYM-r) > ENC_PAR_BUF_DEP, sel_request > ENC_SYM, or an undefined sel_phase encoding.
  - Setting sel_err does not alter the data path.
- Undefined: port absent, no checking logic; clamping and zero-fill still apply.

Test Plan:
- Reset: rst=1 for 2 cycles with sel_phase=SEL_MES -> all outputs 0 and out_cw_cnt=0. Hold SEL_IDL after release -> out_valid stays 0.
- Full message word: SEL_MES, r=4, mes_offset=2, mes_buf[k]=0x10+k, pos=0 -> next cycle valid=1, data lanes {0x12,0x13,0x14,0x15}, sop=1, sop_lane=0.
- Mixed end of message: SEL_MES, r=3, mes_offset=0, par_offset=0, par_buf[k]=0xA0+k -> lanes {0x10,0x11,0x12,0xA0}, sop=0, eop=0.
- Boundary word: SEL_PAR, r=1, par_offset=1, mes_offset=0 -> lanes {0xA1,0xA2,0xA3,0x10}, eop=1, eop_lane=2, sop=1, sop_lane=3. out_cw_cnt goes 0->1 on the same edge; pos becomes 1.
- Sequence of codewords: drive a stream with codeword start at lane 0 -> eop on the word where pos=12 (eop_lane=2), next pos=1. After 65536 codewords out_cw_cnt wraps to 0.
- Checker (ENC_SEL_CHK_EN): SEL_MES, r=4, mes_offset=6 -> sel_err=1 next cycle and stays 1; out lanes 2..3 = 0x00. rst clears sel_err.

Source files
------------

// File: rtl/enc_selector.sv
// RS encoder output stage: assembles one ENC_SYM-symbol word per cycle from the message and
// parity buffers and adds codeword framing. Define ENC_SEL_CHK_EN to add the sticky sel_err_o.
module enc_selector #(
  parameter int unsigned SYM_WID         = 8,
  parameter int unsigned ENC_SYM         = 4,
  parameter int unsigned RSC_MES_LEN     = 11,
  parameter int unsigned RSC_PAR_LEN     = 4,
  parameter int unsigned RSC_COD_LEN     = 15,
  parameter int unsigned ENC_MES_BUF_DEP = 8,
  parameter int unsigned ENC_PAR_BUF_DEP = 8,
  localparam int unsigned ReqW  = $clog2(ENC_SYM + 1),
  localparam int unsigned MOffW = $clog2(ENC_MES_BUF_DEP + 1),
  localparam int unsigned POffW = $clog2(ENC_PAR_BUF_DEP + 1),
  localparam int unsigned LaneW = $clog2(ENC_SYM)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [1:0]                         sel_phase_i,
  input  logic [ReqW-1:0]                    sel_request_i,
  input  logic [MOffW-1:0]                   sel_mes_offset_i,
  input  logic [POffW-1:0]                   sel_par_offset_i,
  input  logic [ENC_MES_BUF_DEP*SYM_WID-1:0] mes_buf_i,
  input  logic [ENC_PAR_BUF_DEP*SYM_WID-1:0] par_buf_i,
  output logic                               out_valid_o,
  output logic [ENC_SYM*SYM_WID-1:0]         out_data_o,
  output logic                               out_sop_o,
  output logic [LaneW-1:0]                   out_sop_lane_o,
  output logic                               out_eop_o,
  output logic [LaneW-1:0]                   out_eop_lane_o,
`ifdef ENC_SEL_CHK_EN
  output logic                               sel_err_o,
`endif
  output logic [15:0]                        out_cw_cnt_o
);

  localparam int unsigned PosW  = $clog2(RSC_COD_LEN);
  localparam int unsigned MIdxW = MOffW + 1;
  localparam int unsigned PIdxW = POffW + 1;

  localparam logic [1:0] SelIdl = 2'd0;
  localparam logic [1:0] SelPar = 2'd1;
  localparam logic [1:0] SelMes = 2'd2;

  logic                       valid_q, valid_d;
  logic [ENC_SYM*SYM_WID-1:0] data_q, data_d;
  logic                       sop_q, sop_d;
  logic [LaneW-1:0]           sop_lane_q, sop_lane_d;
  logic                       eop_q, eop_d;
  logic [LaneW-1:0]           eop_lane_q, eop_lane_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [PosW-1:0]            pos_q, pos_d;

  int unsigned      req;
  int unsigned      pos_sum;
  int unsigned      pos_wrap;
  logic             is_valid;
  logic [MIdxW-1:0] mes_idx;
  logic [PIdxW-1:0] par_idx;

  // Word composition: each lane picks either a message or a parity symbol; indices past the
  // buffer depth read as zero.
  always_comb begin
    req      = (int'(sel_request_i) > int'(ENC_SYM)) ? ENC_SYM : int'(sel_request_i);
    is_valid = (sel_phase_i == SelMes) || (sel_phase_i == SelPar);
    mes_idx  = '0;
    par_idx  = '0;
    data_d   = '0;
    for (int unsigned i = 0; i < ENC_SYM; i++) begin
      if ((sel_phase_i == SelMes && i < req) ||
          (sel_phase_i == SelPar && i >= ENC_SYM - req)) begin
        mes_idx = {1'b0, sel_mes_offset_i} +
                  MIdxW'((sel_phase_i == SelMes) ? i : i - (ENC_SYM - req));
        if (int'(mes_idx) < int'(ENC_MES_BUF_DEP)) begin
          data_d[i*SYM_WID +: SYM_WID] = mes_buf_i[int'(mes_idx)*SYM_WID +: SYM_WID];
        end
      end else begin
        par_idx = {1'b0, sel_par_offset_i} +
                  PIdxW'((sel_phase_i == SelMes) ? i - req : i);
        if (int'(par_idx) < int'(ENC_PAR_BUF_DEP)) begin
          data_d[i*SYM_WID +: SYM_WID] = par_buf_i[int'(par_idx)*SYM_WID +: SYM_WID];
        end
      end
    end
  end

  // Framing and lane-0 position tracking.
  always_comb begin
    pos_sum    = int'(pos_q) + ENC_SYM;
    pos_wrap   = (pos_sum >= RSC_COD_LEN) ? pos_sum - RSC_COD_LEN : pos_sum;
    valid_d    = is_valid;
    sop_d      = sop_q;
    sop_lane_d = sop_lane_q;
    eop_d      = eop_q;
    eop_lane_d = eop_lane_q;
    pos_d      = pos_q;
    if (is_valid) begin
      sop_d      = 1'b0;
      sop_lane_d = '0;
      eop_d      = 1'b0;
      eop_lane_d = '0;
      pos_d      = PosW'(pos_wrap);
      if (sel_phase_i == SelMes) begin
        sop_d = (pos_q == '0);
      end else if (req > 0 && req < ENC_SYM) begin
        // Boundary word: parity tail of one codeword followed by the head of the next.
        eop_d      = 1'b1;
        eop_lane_d = LaneW'(ENC_SYM - req - 1);
        sop_d      = 1'b1;
        sop_lane_d = LaneW'(ENC_SYM - req);
        pos_d      = PosW'(req);
      end else if (req == 0 && pos_sum >= RSC_COD_LEN) begin
        eop_d      = 1'b1;
        eop_lane_d = LaneW'(RSC_COD_LEN - 1 - int'(pos_q));
        pos_d      = PosW'(pos_sum - RSC_COD_LEN);
      end
    end
    cnt_d = cnt_q + {15'd0, is_valid & eop_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      sop_lane_q <= '0;
      eop_q      <= 1'b0;
      eop_lane_q <= '0;
      cnt_q      <= '0;
      pos_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      sop_lane_q <= sop_lane_d;
      eop_q      <= eop_d;
      eop_lane_q <= eop_lane_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      if (is_valid) begin
        data_q <= data_d;
      end
    end
  end

`ifdef ENC_SEL_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (is_valid &&
        ((int'(sel_mes_offset_i) + req > ENC_MES_BUF_DEP) ||
         (int'(sel_par_offset_i) + (ENC_SYM - req) > ENC_PAR_BUF_DEP) ||
         (int'(sel_request_i) > int'(ENC_SYM)))) begin
      err_d = 1'b1;
    end
    if (sel_phase_i != SelIdl && !is_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sel_err_o = err_q;
`endif

  assign out_valid_o    = valid_q;
  assign out_data_o     = data_q;
  assign out_sop_o      = sop_q;
  assign out_sop_lane_o = sop_lane_q;
  assign out_eop_o      = eop_q;
  assign out_eop_lane_o = eop_lane_q;
  assign out_cw_cnt_o   = cnt_q;

endmodule

// File: tb/tb_enc_selector.sv
// Directed, table-driven bench for enc_selector (default parameters, mes[k]=0x10+k, par[k]=0xA0+k).
module tb_enc_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_phase;
  logic [2:0]  sel_request;
  logic [3:0]  sel_mes_offset;
  logic [3:0]  sel_par_offset;
  logic [63:0] mes_buf;
  logic [63:0] par_buf;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sop;
  logic [1:0]  out_sop_lane;
  logic        out_eop;
  logic [1:0]  out_eop_lane;
  logic [15:0] out_cw_cnt;
`ifdef ENC_SEL_CHK_EN
  logic        sel_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enc_selector dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .sel_phase_i      (sel_phase),
    .sel_request_i    (sel_request),
    .sel_mes_offset_i (sel_mes_offset),
    .sel_par_offset_i (sel_par_offset),
    .mes_buf_i        (mes_buf),
    .par_buf_i        (par_buf),
    .out_valid_o      (out_valid),
    .out_data_o       (out_data),
    .out_sop_o        (out_sop),
    .out_sop_lane_o   (out_sop_lane),
    .out_eop_o        (out_eop),
    .out_eop_lane_o   (out_eop_lane),
`ifdef ENC_SEL_CHK_EN
    .sel_err_o        (sel_err),
`endif
    .out_cw_cnt_o     (out_cw_cnt)
  );

  typedef struct {
    logic [1:0]  ph;
    logic [2:0]  req;
    logic [3:0]  mo;
    logic [3:0]  po;
    logic        val;
    logic [31:0] data;
    logic        sop;
    logic [1:0]  sl;
    logic        eop;
    logic [1:0]  el;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ph, input logic [2:0] req, input logic [3:0] mo,
                       input logic [3:0] po);
    sel_phase      = ph;
    sel_request    = req;
    sel_mes_offset = mo;
    sel_par_offset = po;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic val, input logic [31:0] data,
                         input logic sop, input logic [1:0] sl, input logic eop,
                         input logic [1:0] el, input logic [15:0] cnt);
    chk({tag, ".valid"}, 32'(out_valid), 32'(val));
    chk({tag, ".data"}, out_data, data);
    chk({tag, ".sop"}, {out_sop, 2'b0, out_sop_lane}, {sop, 2'b0, sl});
    chk({tag, ".eop"}, {out_eop, 2'b0, out_eop_lane}, {eop, 2'b0, el});
    chk({tag, ".cnt"}, 32'(out_cw_cnt), 32'(cnt));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mes_buf[k*8 +: 8] = 8'h10 + 8'(k);
      par_buf[k*8 +: 8] = 8'hA0 + 8'(k);
    end
    //          ph     req   mo    po    val   data          sop   sl    eop   el    cnt
    vecs[0]  = '{2'd0, 3'd0, 4'd0, 4'd0, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0};
    vecs[1]  = '{2'd2, 3'd4, 4'd2, 4'd0, 1'b1, 32'h15141312, 1'b1, 2'd0, 1'b0, 2'd0, 16'd0};
    vecs[2]  = '{2'd2, 3'd3, 4'd0, 4'd0, 1'b1, 32'hA0121110, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0};
    vecs[3]  = '{2'd1, 3'd1, 4'd0, 4'd1, 1'b1, 32'h10A3A2A1, 1'b1, 2'd3, 1'b1, 2'd2, 16'd1};
    vecs[4]  = '{2'd0, 3'd0, 4'd0, 4'd0, 1'b0, 32'h10A3A2A1, 1'b1, 2'd3, 1'b1, 2'd2, 16'd1};
    vecs[5]  = '{2'd2, 3'd4, 4'd0, 4'd0, 1'b1, 32'h13121110, 1'b0, 2'd0, 1'b0, 2'd0, 16'd1};
    vecs[6]  = '{2'd2, 3'd4, 4'd4, 4'd0, 1'b1, 32'h17161514, 1'b0, 2'd0, 1'b0, 2'd0, 16'd1};
    vecs[7]  = '{2'd2, 3'd2, 4'd0, 4'd0, 1'b1, 32'hA1A01110, 1'b0, 2'd0, 1'b0, 2'd0, 16'd1};
    vecs[8]  = '{2'd1, 3'd0, 4'd0, 4'd2, 1'b1, 32'hA5A4A3A2, 1'b0, 2'd0, 1'b1, 2'd1, 16'd2};
    vecs[9]  = '{2'd2, 3'd7, 4'd0, 4'd0, 1'b1, 32'h13121110, 1'b0, 2'd0, 1'b0, 2'd0, 16'd2};
    vecs[10] = '{2'd2, 3'd4, 4'd6, 4'd0, 1'b1, 32'h00001716, 1'b0, 2'd0, 1'b0, 2'd0, 16'd2};
    vecs[11] = '{2'd1, 3'd4, 4'd7, 4'd0, 1'b1, 32'h00000017, 1'b0, 2'd0, 1'b0, 2'd0, 16'd2};
    vecs[12] = '{2'd1, 3'd0, 4'd0, 4'd4, 1'b1, 32'hA7A6A5A4, 1'b0, 2'd0, 1'b1, 2'd0, 16'd3};
    vecs[13] = '{2'd3, 3'd0, 4'd0, 4'd0, 1'b0, 32'hA7A6A5A4, 1'b0, 2'd0, 1'b1, 2'd0, 16'd3};

    // Reset held for two cycles while a message word is offered.
    rst = 1'b1;
    drive(2'd2, 3'd4, 4'd0, 4'd0);
    chk_all("rst0", 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0);
    drive(2'd2, 3'd4, 4'd0, 4'd0);
    chk_all("rst1", 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0);
    rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].ph, vecs[v].req, vecs[v].mo, vecs[v].po);
      chk_all($sformatf("vec%0d", v), vecs[v].val, vecs[v].data, vecs[v].sop, vecs[v].sl,
              vecs[v].eop, vecs[v].el, vecs[v].cnt);
    end

    // Reset asserted while a word is offered discards it.
    rst = 1'b1;
    drive(2'd2, 3'd4, 4'd0, 4'd0);
    chk_all("rst_mid", 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0);
    rst = 1'b0;

    // Codeword starting on lane 0: 11 message symbols then 4 parity, eop at pos 12.
    drive(2'd2, 3'd4, 4'd0, 4'd0);
    chk_all("cw_a", 1'b1, 32'h13121110, 1'b1, 2'd0, 1'b0, 2'd0, 16'd0);
    drive(2'd2, 3'd4, 4'd4, 4'd0);
    chk_all("cw_b", 1'b1, 32'h17161514, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0);
    drive(2'd2, 3'd3, 4'd0, 4'd0);
    chk_all("cw_c", 1'b1, 32'hA0121110, 1'b0, 2'd0, 1'b0, 2'd0, 16'd0);
    drive(2'd1, 3'd0, 4'd0, 4'd1);
    chk_all("cw_d", 1'b1, 32'hA4A3A2A1, 1'b0, 2'd0, 1'b1, 2'd2, 16'd1);
    drive(2'd2, 3'd4, 4'd0, 4'd0);
    chk_all("cw_e", 1'b1, 32'h13121110, 1'b0, 2'd0, 1'b0, 2'd0, 16'd1);

    // 65536 boundary words, each closing a codeword: the count comes back to 1.
    for (int n = 0; n < 65536; n++) begin
      drive(2'd1, 3'd1, 4'd0, 4'd0);
    end
    chk_all("wrap", 1'b1, 32'h10A2A1A0, 1'b1, 2'd3, 1'b1, 2'd2, 16'd1);

`ifdef ENC_SEL_CHK_EN
    rst = 1'b1;
    drive(2'd0, 3'd0, 4'd0, 4'd0);
    rst = 1'b0;
    chk("err_rst", 32'(sel_err), 32'd0);
    drive(2'd2, 3'd4, 4'd6, 4'd0);
    chk("err_set", 32'(sel_err), 32'd1);
    chk("err_data", out_data, 32'h00001716);
    drive(2'd0, 3'd0, 4'd0, 4'd0);
    chk("err_sticky", 32'(sel_err), 32'd1);
    rst = 1'b1;
    drive(2'd0, 3'd0, 4'd0, 4'd0);
    rst = 1'b0;
    chk("err_clr", 32'(sel_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
